mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It extends the single-cycle EX-stage ALU with MULT/MULTU/DIV/DIVU/MTHI/MTLO. It sits beside the ALU in EX and is launched by a one-cycle start pulse. While busy, the hazard logic stalls any instruction that reads or writes HI/LO.

---
 rtl/mul_div_unit.sv | 155 +++++++++++++++
 tb/tb_mul_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Optional single-cycle multiply when MULDIV_FAST_MULT_EN is defined.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} stateT;
  stateT state, nextState;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   magA, magB, accHi, accLo;
  logic               negA, negB, divOp;
  logic               isSigned, launch, lastIter;
  logic [WIDTH-1:0]   absA, absB, quot, rem, signedA;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH+1:0]   divTrial;
  logic [2*WIDTH-1:0] prod;

  assign isSigned = ~op[0];
  // Most-negative operand negates to itself; read unsigned it is the right magnitude.
  assign absA = (isSigned && src_a[WIDTH-1]) ? -src_a : src_a;
  assign absB = (isSigned && src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastProd = op[0]
    ? {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b}
    : {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign launch = start && !op[2] && op[1];
`else
  assign launch = start && !op[2];
`endif

  assign lastIter = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE:  if (launch) nextState = CALC;
      CALC: begin
        busy = 1'b1;
        if (abort)         nextState = IDLE;
        else if (lastIter) nextState = FIXUP;
      end
      FIXUP: begin
        busy      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Multiply: accLo holds the multiplier and shifts out LSB-first while the
  // product grows into accHi. Divide: accHi is the partial remainder, accLo
  // shifts dividend bits out and quotient bits in.
  assign mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? magA : {WIDTH{1'b0}})};
  assign divTrial = {1'b0, accHi, accLo[WIDTH-1]} - {2'b00, magB};

  assign prod    = (negA ^ negB) ? -{accHi, accLo} : {accHi, accLo};
  assign quot    = (negA ^ negB) ? -accLo : accLo;
  assign rem     = negA ? -accHi : accHi;
  assign signedA = negA ? -magA : magA;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      magA  <= '0;
      magB  <= '0;
      accHi <= '0;
      accLo <= '0;
      negA  <= 1'b0;
      negB  <= 1'b0;
      divOp <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op[2:1] == 2'b10) begin
            if (op[0]) lo <= src_a;
            else       hi <= src_a;
          end
`ifdef MULDIV_FAST_MULT_EN
          else if (op[2:1] == 2'b00) begin
            hi   <= fastProd[2*WIDTH-1:WIDTH];
            lo   <= fastProd[WIDTH-1:0];
            done <= 1'b1;
          end
`endif
          else if (launch) begin
            magA  <= absA;
            magB  <= absB;
            negA  <= isSigned && src_a[WIDTH-1];
            negB  <= isSigned && src_b[WIDTH-1];
            divOp <= op[1];
            cnt   <= '0;
            accHi <= '0;
            accLo <= op[1] ? absA : absB;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (divOp) begin
            if (!divTrial[WIDTH+1]) begin
              accHi <= divTrial[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b1};
            end else begin
              accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
              accLo <= {accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        FIXUP: if (!abort) begin
          done <= 1'b1;
          if (!divOp) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (magB == '0) begin
            hi <= signedA;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [2:0]   op;
  logic [W-1:0] srcA, srcB;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(srcA), .src_b(srcB), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
      3'd2: begin
        if (b == 0) return {a, 32'hffffffff};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hffffffff};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hffffffff;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done is expected.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] e;
    int n;
    e = model(o, a, b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk({tag, ".lat"}, 64'(n), (FAST && !o[1]) ? 64'd0 : 64'd33);
    chk({tag, ".done"}, 64'(done), 64'd1);
    expHi = e[63:32];
    expLo = e[31:0];
    chk({tag, ".hi"}, 64'(hi), 64'(expHi));
    chk({tag, ".lo"}, 64'(lo), 64'(expLo));
  endtask

  task automatic doMove(input bit toLo, input logic [31:0] d, input string tag);
    start = 1'b1; op = toLo ? 3'b101 : 3'b100; srcA = d; srcB = ~d;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    if (toLo) expLo = d; else expHi = d;
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(expHi));
    chk({tag, ".lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int n;
    bit sawDone;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 3'b111; srcA = '0; srcB = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp(3'd0, 32'hfffffffd, 32'd5, "mult");
    @(negedge clk);
    chk("mult.pulse", 64'(done), 64'd0);
    runOp(3'd1, 32'hffffffff, 32'hffffffff, "multu");
    runOp(3'd2, 32'hfffffff9, 32'd2, "div");
    runOp(3'd2, 32'h80000000, 32'hffffffff, "divovf");
    runOp(3'd3, 32'd100, 32'd0, "divu0");
    runOp(3'd2, 32'hfffffff0, 32'd0, "div0");
    runOp(3'd0, 32'h80000000, 32'h80000000, "multmin");

    doMove(1'b0, 32'h12345678, "mthi");
    doMove(1'b1, 32'h9abcdef0, "mtlo");

    // Abort in the 10th busy cycle.
    start = 1'b1; op = 3'b011; srcA = 32'd10; srcB = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    repeat (9) @(negedge clk);
    chk("abort.pre", 64'(busy), 64'd1);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    sawDone = done;
    repeat (W + 2) begin @(negedge clk); sawDone |= done; end
    chk("abort.nodone", 64'(sawDone), 64'd0);
    chk("abort.hi", 64'(hi), 64'(expHi));
    chk("abort.lo", 64'(lo), 64'(expLo));

    // No-op opcode is ignored.
    start = 1'b1; op = 3'b110; srcA = 32'hdeadbeef; srcB = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    chk("nop.busy", 64'(busy), 64'd0);
    chk("nop.hi", 64'(hi), 64'(expHi));
    chk("nop.lo", 64'(lo), 64'(expLo));

    // A second start while busy must not disturb the first operation.
    start = 1'b1; op = 3'b011; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    n = 0;
    repeat (5) begin n++; @(negedge clk); end
    start = 1'b1; op = 3'b011; srcA = 32'd50; srcB = 32'd5;
    n++; @(negedge clk);
    start = 1'b0; op = 3'b111;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("ign.lat", 64'(n), 64'd33);
    chk("ign.done", 64'(done), 64'd1);
    expHi = 32'd2; expLo = 32'd14;
    chk("ign.hi", 64'(hi), 64'(expHi));
    chk("ign.lo", 64'(lo), 64'(expLo));
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) doMove(1'($urandom_range(0, 1)), 32'($urandom), "rndmv");
      runOp(3'($urandom_range(0, 3)), pick(), pick(), "rnd");
    end

    // Reset in the 20th busy cycle.
    start = 1'b1; op = 3'b011; srcA = 32'd12345; srcB = 32'd17;
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'b111;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    chk("mrst.hi", 64'(hi), 64'd0);
    chk("mrst.lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    runOp(3'd3, 32'd1000, 32'd7, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
